// File: rtl/sdio_init_seq.sv
// SD card identification sequencer: power-up delay, CMD0/8/55+ACMD41/2/3/7,
// optional 4-bit bus switch and CMD16, with response checks, retries and capture.
module sdio_init_seq #(
  parameter int POWERUP_CYC = 4000,
  parameter int GAP_CYC     = 10,
  parameter int RSP_TIMEOUT = 1000,
  parameter int CMD_RETRY   = 3,
  parameter int ACMD41_MAX  = 1000,
  parameter int BUS_4BIT    = 1,
  parameter int BLOCK_LEN   = 512
) (
  input  logic         ctrl_clk,
  input  logic         rst,
  output logic         o_tx_en,
  output logic [5:0]   o_tx_cmd,
  output logic [31:0]  o_tx_para,
  input  logic         i_tx_busy,
  output logic         o_rx_listen,
  output logic         o_rx_rsp136en,
  input  logic         i_rx_de,
  input  logic         i_rx_crc7_down,
  input  logic [5:0]   i_rx_cmd,
  input  logic [31:0]  i_rx_para,
  input  logic [119:0] i_rx_cid,
  input  logic         i_rx_busy,
  output logic         init_down,
  output logic         o_init_err,
  output logic [3:0]   o_err_code,
  output logic [15:0]  o_rca,
  output logic         o_card_hc,
  output logic [119:0] o_cid,
  output logic [3:0]   o_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PWRUP  = 4'd1;
  localparam logic [3:0] S_CMD0   = 4'd2;
  localparam logic [3:0] S_CMD8   = 4'd3;
  localparam logic [3:0] S_CMD55  = 4'd4;
  localparam logic [3:0] S_ACMD41 = 4'd5;
  localparam logic [3:0] S_CMD2   = 4'd6;
  localparam logic [3:0] S_CMD3   = 4'd7;
  localparam logic [3:0] S_CMD7   = 4'd8;
  localparam logic [3:0] S_CMD55B = 4'd9;
  localparam logic [3:0] S_ACMD6  = 4'd10;
  localparam logic [3:0] S_CMD16  = 4'd11;
  localparam logic [3:0] S_DONE   = 4'd12;
  localparam logic [3:0] S_ERR    = 4'd15;

  typedef enum logic [2:0] {
    PH_ISSUE   = 3'd0,
    PH_LAUNCH  = 3'd1,
    PH_WAIT_TX = 3'd2,
    PH_GAP     = 3'd3,
    PH_LISTEN  = 3'd4
  } phase_e;

  localparam int CNT_MAX = (POWERUP_CYC > RSP_TIMEOUT) ?
                           ((POWERUP_CYC > GAP_CYC) ? POWERUP_CYC : GAP_CYC) :
                           ((RSP_TIMEOUT > GAP_CYC) ? RSP_TIMEOUT : GAP_CYC);
  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int RTY_W = (CMD_RETRY < 1) ? 1 : $clog2(CMD_RETRY + 1);
  localparam int ITR_W = (ACMD41_MAX < 1) ? 1 : $clog2(ACMD41_MAX + 1);

  function automatic logic [5:0] cmd_index(input logic [3:0] s);
    case (s)
      S_CMD8:           return 6'd8;
      S_CMD55, S_CMD55B: return 6'd55;
      S_ACMD41:         return 6'd41;
      S_CMD2:           return 6'd2;
      S_CMD3:           return 6'd3;
      S_CMD7:           return 6'd7;
      S_ACMD6:          return 6'd6;
      S_CMD16:          return 6'd16;
      default:          return 6'd0;
    endcase
  endfunction

  // R2 and R3 responses carry the reserved index 0x3F instead of an echo.
  function automatic logic [5:0] rsp_index(input logic [3:0] s);
    case (s)
      S_ACMD41, S_CMD2: return 6'h3F;
      default:          return cmd_index(s);
    endcase
  endfunction

  function automatic logic [31:0] cmd_arg(input logic [3:0] s, input logic v2,
                                          input logic [15:0] rca);
    case (s)
      S_CMD8:           return 32'h0000_01AA;
      S_ACMD41:         return v2 ? 32'h40FF_8000 : 32'h00FF_8000;
      S_CMD7, S_CMD55B: return {rca, 16'h0000};
      S_ACMD6:          return 32'h0000_0002;
      S_CMD16:          return 32'(BLOCK_LEN);
      default:          return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] next_cmd(input logic [3:0] s);
    case (s)
      S_CMD0:   return S_CMD8;
      S_CMD8:   return S_CMD55;
      S_CMD55:  return S_ACMD41;
      S_ACMD41: return S_CMD2;
      S_CMD2:   return S_CMD3;
      S_CMD3:   return S_CMD7;
      S_CMD7:   return (BUS_4BIT != 0) ? S_CMD55B : S_CMD16;
      S_CMD55B: return S_ACMD6;
      S_ACMD6:  return S_CMD16;
      S_CMD16:  return S_DONE;
      default:  return S_ERR;
    endcase
  endfunction

  logic [3:0]       state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [ITR_W-1:0] iter_q, iter_d;
  logic             v2_q, v2_d;
  logic [15:0]      rca_q, rca_d;
  logic             hc_q, hc_d;
  logic [119:0]     cid_q, cid_d;
  logic [3:0]       code_q, code_d;
  logic             tx_en_q, tx_en_d;
  logic [5:0]       tx_cmd_q, tx_cmd_d;
  logic [31:0]      tx_para_q, tx_para_d;
  logic             listen_q, listen_d;
  logic             rsp136_q, rsp136_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic adv_s, fail_s, tmo_s, notready_s, fatal_s, rsp_ok_s, is_cmd_s;
  logic unused_s;

  assign unused_s = ^{i_rx_busy, i_rx_para[15:12]};
  assign is_cmd_s = (state_q >= S_CMD0) && (state_q <= S_CMD16);

  // State register: sequencer state, counters, captured card data and outputs.
  always_ff @(posedge ctrl_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_ISSUE;
      cnt_q     <= {CNT_W{1'b0}};
      retry_q   <= {RTY_W{1'b0}};
      iter_q    <= {ITR_W{1'b0}};
      v2_q      <= 1'b0;
      rca_q     <= 16'h0000;
      hc_q      <= 1'b0;
      cid_q     <= 120'd0;
      code_q    <= 4'd0;
      tx_en_q   <= 1'b0;
      tx_cmd_q  <= 6'd0;
      tx_para_q <= 32'd0;
      listen_q  <= 1'b0;
      rsp136_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      iter_q    <= iter_d;
      v2_q      <= v2_d;
      rca_q     <= rca_d;
      hc_q      <= hc_d;
      cid_q     <= cid_d;
      code_q    <= code_d;
      tx_en_q   <= tx_en_d;
      tx_cmd_q  <= tx_cmd_d;
      tx_para_q <= tx_para_d;
      listen_q  <= listen_d;
      rsp136_q  <= rsp136_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: power-up wait, per-command micro-sequence, response evaluation.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    iter_d     = iter_q;
    v2_d       = v2_q;
    rca_d      = rca_q;
    hc_d       = hc_q;
    cid_d      = cid_q;
    code_d     = code_q;
    adv_s      = 1'b0;
    fail_s     = 1'b0;
    tmo_s      = 1'b0;
    notready_s = 1'b0;
    fatal_s    = 1'b0;
    rsp_ok_s   = (i_rx_crc7_down || (state_q == S_ACMD41)) &&
                 (i_rx_cmd == rsp_index(state_q));
    case (state_q)
      S_IDLE: begin
        state_d = S_PWRUP;
        cnt_d   = {CNT_W{1'b0}};
      end
      S_PWRUP: begin
        if (int'(cnt_q) + 32'sd1 >= POWERUP_CYC) begin
          state_d = S_CMD0;
          phase_d = PH_ISSUE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE, S_ERR: begin
        state_d = state_q;
      end
      default: begin
        case (phase_q)
          PH_ISSUE: begin
            if (!i_tx_busy) phase_d = PH_LAUNCH;
            else            phase_d = PH_ISSUE;
          end
          PH_LAUNCH: phase_d = PH_WAIT_TX;
          PH_WAIT_TX: begin
            if (!i_tx_busy) begin
              phase_d = PH_GAP;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              phase_d = PH_WAIT_TX;
            end
          end
          PH_GAP: begin
            if (int'(cnt_q) + 32'sd1 >= GAP_CYC) begin
              if (state_q == S_CMD0) begin
                adv_s = 1'b1;
              end else begin
                phase_d = PH_LISTEN;
                cnt_d   = {CNT_W{1'b0}};
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PH_LISTEN: begin
            if (i_rx_de) begin
              case (state_q)
                S_CMD8: begin
                  if (!rsp_ok_s)                         fail_s  = 1'b1;
                  else if (i_rx_para[11:0] != 12'h1AA)   fatal_s = 1'b1;
                  else begin v2_d = 1'b1; adv_s = 1'b1; end
                end
                S_ACMD41: begin
                  if (rsp_ok_s && i_rx_para[31]) begin
                    hc_d  = i_rx_para[30] & v2_q;
                    adv_s = 1'b1;
                  end else begin
                    notready_s = 1'b1;
                  end
                end
                S_CMD2: begin
                  if (rsp_ok_s) begin cid_d = i_rx_cid; adv_s = 1'b1; end
                  else          fail_s = 1'b1;
                end
                S_CMD3: begin
                  if (rsp_ok_s && (i_rx_para[31:16] != 16'h0000)) begin
                    rca_d = i_rx_para[31:16];
                    adv_s = 1'b1;
                  end else begin
                    fail_s = 1'b1;
                  end
                end
                default: begin
                  if (rsp_ok_s) adv_s  = 1'b1;
                  else          fail_s = 1'b1;
                end
              endcase
            end else if (int'(cnt_q) + 32'sd1 >= RSP_TIMEOUT) begin
              if (state_q == S_ACMD41) begin
                notready_s = 1'b1;
              end else begin
                fail_s = 1'b1;
                tmo_s  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: phase_d = PH_ISSUE;
        endcase
      end
    endcase

    // A silent CMD8 after all retries identifies a v1 card rather than a fault.
    if (fail_s) begin
      if (int'(retry_q) < CMD_RETRY) begin
        retry_d = retry_q + RTY_W'(1);
        phase_d = PH_ISSUE;
      end else if ((state_q == S_CMD8) && tmo_s) begin
        v2_d  = 1'b0;
        adv_s = 1'b1;
      end else begin
        fatal_s = 1'b1;
      end
    end else begin
      retry_d = retry_d;
    end

    if (notready_s) begin
      if (int'(iter_q) + 32'sd1 >= ACMD41_MAX) begin
        fatal_s = 1'b1;
      end else begin
        iter_d  = iter_q + ITR_W'(1);
        state_d = S_CMD55;
        phase_d = PH_ISSUE;
        retry_d = {RTY_W{1'b0}};
      end
    end else begin
      iter_d = iter_d;
    end

    if (adv_s) begin
      state_d = next_cmd(state_q);
      phase_d = PH_ISSUE;
      retry_d = {RTY_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      state_d = state_d;
    end

    if (fatal_s) begin
      state_d = S_ERR;
      code_d  = state_q;
    end else begin
      code_d = code_d;
    end
  end

  // Output logic: launch strobe with command fields, listen/R2 flags, status.
  always_comb begin
    tx_en_d   = 1'b0;
    tx_cmd_d  = 6'd0;
    tx_para_d = 32'd0;
    if (is_cmd_s && (phase_q == PH_ISSUE) && !i_tx_busy) begin
      tx_en_d   = 1'b1;
      tx_cmd_d  = cmd_index(state_q);
      tx_para_d = cmd_arg(state_q, v2_q, rca_q);
    end else begin
      tx_en_d = 1'b0;
    end
    listen_d = (phase_d == PH_LISTEN) && (state_d >= S_CMD0) && (state_d <= S_CMD16);
    rsp136_d = listen_d && (state_d == S_CMD2);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
  end

  assign o_tx_en       = tx_en_q;
  assign o_tx_cmd      = tx_cmd_q;
  assign o_tx_para     = tx_para_q;
  assign o_rx_listen   = listen_q;
  assign o_rx_rsp136en = rsp136_q;
  assign init_down     = done_q;
  assign o_init_err    = err_q;
  assign o_err_code    = code_q;
  assign o_rca         = rca_q;
  assign o_card_hc     = hc_q;
  assign o_cid         = cid_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_sdio_init_seq.sv
// Bench for sdio_init_seq: two instances (4-bit bus on / off), each driven by a
// randomized card model and checked against a command-list reference model.
module tb_sdio_init_seq;

  localparam int PWR  = 40;
  localparam int GAP  = 4;
  localparam int TMO  = 30;
  localparam int RTY  = 3;
  localparam int AMAX = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fin_cnt  = 0;

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int BUS4 = (g == 0) ? 1 : 0;

    logic         rst = 1'b1;
    logic         tx_en, tx_busy = 1'b0, listen, r136;
    logic [5:0]   tx_cmd;
    logic [31:0]  tx_para;
    logic         rx_de = 1'b0, rx_crc = 1'b0, rx_busy = 1'b0;
    logic [5:0]   rx_cmd = 6'd0;
    logic [31:0]  rx_para = 32'd0;
    logic [119:0] rx_cid = 120'd0;
    logic         done, ierr, hc;
    logic [3:0]   ecode, st;
    logic [15:0]  rca;
    logic [119:0] cid;

    sdio_init_seq #(
      .POWERUP_CYC(PWR), .GAP_CYC(GAP), .RSP_TIMEOUT(TMO), .CMD_RETRY(RTY),
      .ACMD41_MAX(AMAX), .BUS_4BIT(BUS4), .BLOCK_LEN(512)
    ) dut (
      .ctrl_clk(clk), .rst(rst),
      .o_tx_en(tx_en), .o_tx_cmd(tx_cmd), .o_tx_para(tx_para), .i_tx_busy(tx_busy),
      .o_rx_listen(listen), .o_rx_rsp136en(r136),
      .i_rx_de(rx_de), .i_rx_crc7_down(rx_crc), .i_rx_cmd(rx_cmd), .i_rx_para(rx_para),
      .i_rx_cid(rx_cid), .i_rx_busy(rx_busy),
      .init_down(done), .o_init_err(ierr), .o_err_code(ecode),
      .o_rca(rca), .o_card_hc(hc), .o_cid(cid), .o_state(st)
    );

    // card scenario
    bit          cfg_v1, cfg_p30, cfg_bad_rca0, cfg_stray;
    int          cfg_busy, busy_left, bad_left, cfg_bad;
    logic [15:0] cfg_rca;

    logic [37:0] log_m [0:255];
    int          log_n = 0;
    logic [37:0] exp_m [0:255];
    int          exp_n;
    bit          exp_done;
    bit          exp_hc;
    logic [3:0]  exp_code;

    task automatic push(input logic [5:0] c, input logic [31:0] a);
      exp_m[exp_n] = {c, a};
      exp_n++;
    endtask

    // Expected command list and final status, derived from the card scenario.
    task automatic build_expect();
      logic [31:0] a41;
      exp_n = 0;
      push(6'd0, 32'd0);
      if (cfg_v1) begin
        for (int i = 0; i < 1 + RTY; i++) push(6'd8, 32'h1AA);
      end else begin
        push(6'd8, 32'h1AA);
      end
      a41 = cfg_v1 ? 32'h00FF8000 : 32'h40FF8000;
      if (cfg_busy < 0) begin
        for (int i = 0; i < AMAX; i++) begin push(6'd55, 32'd0); push(6'd41, a41); end
        exp_done = 1'b0; exp_hc = 1'b0; exp_code = 4'd5;
      end else begin
        for (int i = 0; i <= cfg_busy; i++) begin push(6'd55, 32'd0); push(6'd41, a41); end
        push(6'd2, 32'd0);
        for (int i = 0; i <= cfg_bad; i++) push(6'd3, 32'd0);
        push(6'd7, {cfg_rca, 16'h0});
        if (BUS4 != 0) begin push(6'd55, {cfg_rca, 16'h0}); push(6'd6, 32'd2); end
        push(6'd16, 32'd512);
        exp_done = 1'b1; exp_hc = cfg_p30 & !cfg_v1; exp_code = 4'd0;
      end
    endtask

    // Card / TX engine model: logs launches, holds busy, answers while listened to.
    initial begin
      int busy_cnt, dly;
      bit pend;
      logic [5:0] pc;
      logic [31:0] pp;
      logic pcrc;
      busy_cnt = 0; dly = 0; pend = 1'b0; pc = 6'd0; pp = 32'd0; pcrc = 1'b0;
      forever begin
        @(negedge clk);
        rx_de = 1'b0;
        if (rst) begin
          busy_cnt = 0; pend = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
        end else begin
          if (tx_en) begin
            check_eq($sformatf("g%0d tx_en_while_busy", g), tx_busy, 1'b0);
            if (log_n < 256) log_m[log_n] = {tx_cmd, tx_para};
            log_n++;
            busy_cnt = $urandom_range(3, 10);
            tx_busy  = 1'b1;
            dly      = $urandom_range(1, 6);
            pend = 1'b1; pcrc = 1'b1; pc = tx_cmd; pp = 32'h0000_0900;
            case (tx_cmd)
              6'd0: pend = 1'b0;
              6'd8: begin pend = !cfg_v1; pp = 32'h0000_01AA; end
              6'd55: pp = 32'h0000_0120;
              6'd41: begin
                pc = 6'h3F; pcrc = 1'($urandom);
                if (busy_left != 0) begin
                  pp = 32'h00FF8000;
                  if (busy_left > 0) busy_left--;
                end else begin
                  pp = {1'b1, cfg_p30, 30'h00FF8000};
                end
              end
              6'd2: begin pc = 6'h3F; pp = 32'd0; end
              6'd3: begin
                pp = {cfg_rca, 16'h0500};
                if (bad_left > 0) begin
                  bad_left--;
                  if (cfg_bad_rca0) pp = 32'h0000_0500;
                  else              pcrc = 1'b0;
                end
              end
              default: pp = 32'h0000_0900;
            endcase
          end else if (busy_cnt > 0) begin
            busy_cnt--;
            tx_busy = (busy_cnt > 0);
          end
          rx_busy = listen && pend;
          if (listen && pend) begin
            if (dly > 1) dly--;
            else begin
              rx_de = 1'b1; rx_cmd = pc; rx_para = pp; rx_crc = pcrc; pend = 1'b0;
            end
          end else if (!listen && cfg_stray && ($urandom_range(0, 9) == 0)) begin
            rx_de = 1'b1; rx_cmd = 6'h3F; rx_crc = 1'b1;
            rx_para = {2'b11, 30'($urandom)};
          end
        end
      end
    end

    task automatic run_scenario(input string name, input bit v1, input int busy, input int bad,
                                input bit bad_rca0, input logic [15:0] r, input bit p30,
                                input bit stray);
      int cyc;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      cfg_v1 = v1; cfg_busy = busy; busy_left = busy; cfg_bad = bad; bad_left = bad;
      cfg_bad_rca0 = bad_rca0; cfg_rca = r; cfg_p30 = p30; cfg_stray = stray;
      rx_cid = {24'($urandom), $urandom, $urandom, $urandom};
      log_n = 0;
      build_expect();
      rst = 1'b0;
      cyc = 0;
      while (!done && !ierr && cyc < 5000) begin @(negedge clk); cyc++; end
      check_eq($sformatf("g%0d %s finished", g, name), cyc < 5000, 1'b1);
      repeat (20) @(negedge clk);
      check_eq($sformatf("g%0d %s init_down", g, name), done, exp_done);
      check_eq($sformatf("g%0d %s init_err", g, name), ierr, !exp_done);
      check_eq($sformatf("g%0d %s err_code", g, name), ecode, exp_code);
      check_eq($sformatf("g%0d %s tx_count", g, name), log_n, exp_n);
      for (int i = 0; i < exp_n; i++)
        check_eq($sformatf("g%0d %s tx[%0d]", g, name, i), log_m[i], exp_m[i]);
      check_eq($sformatf("g%0d %s rca", g, name), rca, exp_done ? cfg_rca : 16'h0);
      check_eq($sformatf("g%0d %s card_hc", g, name), hc, exp_hc);
      check_eq($sformatf("g%0d %s cid", g, name), cid, exp_done ? rx_cid : 120'd0);
    endtask

    // Abort in CMD2 LISTEN, then verify clean restart through the power-up wait.
    task automatic reset_test();
      int cyc, pwr, txr;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      cfg_v1 = 1'b0; cfg_busy = 0; busy_left = 0; cfg_bad = 0; bad_left = 0;
      cfg_rca = 16'h0042; cfg_p30 = 1'b1; cfg_stray = 1'b0; log_n = 0;
      rst = 1'b0;
      cyc = 0;
      while (!(st == 4'd6 && listen) && cyc < 5000) begin @(negedge clk); cyc++; end
      check_eq($sformatf("g%0d rst reached_cmd2_listen", g), cyc < 5000, 1'b1);
      check_eq($sformatf("g%0d rst rsp136_in_cmd2", g), r136, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_eq($sformatf("g%0d rst ctrl_outputs_zero", g),
               {tx_en, tx_cmd, tx_para, listen, r136, done, ierr, ecode, st}, 51'd0);
      check_eq($sformatf("g%0d rst data_outputs_zero", g), {rca, hc, cid}, 137'd0);
      txr = 0;
      repeat (3) begin @(negedge clk); if (tx_en) txr++; end
      check_eq($sformatf("g%0d rst tx_during_reset", g), txr, 0);
      rst = 1'b0;
      cyc = 0; pwr = 0;
      while (!tx_en && cyc < PWR + 200) begin
        @(negedge clk);
        if (st == 4'd1) pwr++;
        cyc++;
      end
      check_eq($sformatf("g%0d rst pwrup_cycles", g), pwr, PWR);
      check_eq($sformatf("g%0d rst first_cmd", g), {tx_en, tx_cmd}, {1'b1, 6'd0});
    endtask

    initial begin
      run_scenario("sdhc", 1'b0, 2, 0, 1'b0, 16'h1234, 1'b1, 1'b0);
      run_scenario("v1", 1'b1, 1, 0, 1'b0, 16'(($urandom % 16'hFFFE) + 1), 1'b1, 1'b0);
      run_scenario("cmd3_crc", 1'b0, 0, 1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
      run_scenario("cmd3_rca0", 1'b0, 1, 2, 1'b1, 16'h0001, 1'b1, 1'b1);
      run_scenario("acmd41_never", 1'b0, -1, 0, 1'b0, 16'h5555, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++)
        run_scenario($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, RTY),
                     1'($urandom_range(0, 1)), 16'($urandom_range(1, 65535)),
                     1'($urandom_range(0, 1)), 1'b1);
      reset_test();
      rst = 1'b1;
      fin_cnt++;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (fin_cnt < 2 && cyc < 80000) begin @(negedge clk); cyc++; end
    check_eq("all_instances_done", fin_cnt, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
